reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin write arbiter sharing one WIDTH-bit enable-register (data/en/q style) among NUM_REQ requesters.
- Selects one pending requester, drives the register's en and data for exactly one cycle, and returns a one-hot grant.
- Enforces a programmable idle gap between writes.
- Sits directly in front of the shared register; reg_en/reg_data connect to its en/data ports.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- WIDTH, 4, register data width.
- HOLD_CYCLES, 1, idle cycles forced after each write (>=0).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request, level.
- wdata  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  one-hot grant, one-cycle pulse.
- reg_en  output  1  write enable to shared register.
- reg_data  output  WIDTH  write data to shared register.
- last_id  output  max(1,$clog2(NUM_REQ))  index of most recent winner.
- busy  output  1  high in WRITE and HOLD states.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0, all state clears immediately, independent of clk.
- Reset values: state=IDLE, gnt=0, reg_en=0, reg_data=0, last_id=0, busy=0, rr_ptr=0, hold_cnt=0.
- All outputs are registered. No combinational path from req/wdata to any output.
- FSM states: IDLE, WRITE, HOLD.
- IDLE, req==0: stay in IDLE; all outputs low except last_id and reg_data, which hold their values.
- IDLE, req!=0 at a clk edge:
  - Winner = first index i with req[i]=1, scanning rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1.
  - On that edge: gnt <= onehot(winner), reg_en <= 1, reg_data <= wdata slice of winner (sampled on this edge), last_id <= winner, busy <= 1, state <= WRITE.
- WRITE: lasts exactly one cycle.
  - On the exiting edge: gnt <= 0, reg_en <= 0, rr_ptr <= (winner+1) mod NUM_REQ.
  - If HOLD_CYCLES>0: state <= HOLD, hold_cnt <= HOLD_CYCLES-1, busy stays 1.
  - Else: state <= IDLE, busy <= 0.
- HOLD: req is ignored; gnt=0, reg_en=0, busy=1.
  - hold_cnt>0: decrement.
  - hold_cnt==0: state <= IDLE, busy <= 0.
  - HOLD lasts exactly HOLD_CYCLES cycles.
- Latency:
  - req high before edge k gives gnt/reg_en high during cycle k..k+1.
  - Shared register q updates at edge k+1.
  - Write spacing is 2+HOLD_CYCLES cycles minimum.
- Handshake:
  - A requester holds req and its wdata stable until it sees its gnt bit.
  - If req is still high in the cycle after gnt, it counts as a new request.
  - A requester dropping req before being granted withdraws it; no write occurs.
- Round-robin wrap: winner NUM_REQ-1 sets rr_ptr=0.
- NUM_REQ=1: the requester always wins; rr_ptr stays 0.
- Simultaneous requests: exactly one grant per write. No requester waits more than NUM_REQ write slots while continuously requesting.
- gnt is always zero or one-hot. reg_en is 1 iff gnt!=0.
- reg_data holds its last written value when reg_en=0.
- Reset asserted mid-WRITE or mid-HOLD: outputs clear immediately. The in-flight write is aborted if reset precedes the capturing edge. After release, the FSM restarts in IDLE with rr_ptr=0.

Test Plan:
1. Reset, then single request: reset=0 for 2 cycles, release; req=4'b0100, wdata[11:8]=4'hA.
   - Required: gnt=4'b0100 and reg_en=1 for one cycle, reg_data=4'hA, last_id=2.
   - Required: register q=4'hA one edge later; busy high for 2 cycles (HOLD_CYCLES=1).
2. All four request continuously with data 1,2,3,4:
   - Required: grant order 0,1,2,3,0; writes spaced exactly 3 cycles apart.
   - Required: q sequence 1,2,3,4,1.
3. Wrap and fairness: last winner=3; req=4'b1001.
   - Required: requester 0 wins next, then 3; never 3 twice in a row.
4. Hold masking: new req asserted in the HOLD cycle, then dropped before IDLE.
   - Required: no gnt, reg_en stays 0, q unchanged.
5. Async reset mid-WRITE: drive reset low between edges while reg_en=1.
   - Required: gnt=0, reg_en=0, reg_data=0, busy=0 immediately.
   - Required: after release with req=4'b0010, requester 1 wins (rr_ptr reset to 0).
6. HOLD_CYCLES=0 build, req=4'b0001 held high:
   - Required: a write every 2 cycles.
   - Required: gnt pattern 1,0,1,0; busy toggles with reg_en.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters single-cycle write access
// to one shared enable-register, with a programmable idle gap between writes.
module reg_write_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned HOLD_CYCLES = 1,
    localparam int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     reg_en,
    output logic [WIDTH-1:0]         reg_data,
    output logic [IDW-1:0]           last_id,
    output logic                     busy
);

    localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_HOLD
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic               r_reg_en, w_en_nxt;
    logic [WIDTH-1:0]   r_reg_data, w_data_nxt;
    logic [IDW-1:0]     r_last_id, w_last_nxt;
    logic               r_busy, w_busy_nxt;
    logic [IDW-1:0]     r_rr_ptr, w_ptr_nxt;
    logic [HCW-1:0]     r_hold_cnt, w_hold_nxt;

    logic               w_found;
    logic [IDW-1:0]     w_win;

    function automatic logic [IDW-1:0] wrap_idx(input int unsigned base, input int unsigned ofs);
        int unsigned s;
        s = base + ofs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // First requester at or after the round-robin pointer, wrapping once.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[wrap_idx(32'(r_rr_ptr), k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(32'(r_rr_ptr), k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_en_nxt    = 1'b0;
        w_data_nxt  = r_reg_data;
        w_last_nxt  = r_last_id;
        w_busy_nxt  = r_busy;
        w_ptr_nxt   = r_rr_ptr;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_found) begin
                    w_gnt_nxt[w_win] = 1'b1;
                    w_en_nxt         = 1'b1;
                    w_data_nxt       = wdata[32'(w_win)*WIDTH +: WIDTH];
                    w_last_nxt       = w_win;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = S_WRITE;
                end
            end
            S_WRITE: begin
                w_ptr_nxt = wrap_idx(32'(r_last_id), 1);
                if (HOLD_CYCLES > 0) begin
                    w_state_nxt = S_HOLD;
                    w_hold_nxt  = HCW'(HOLD_CYCLES - 1);
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_HOLD: begin
                w_busy_nxt = 1'b1;
                if (r_hold_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_hold_nxt = r_hold_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_reg_en   <= 1'b0;
            r_reg_data <= '0;
            r_last_id  <= '0;
            r_busy     <= 1'b0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_reg_en   <= w_en_nxt;
            r_reg_data <= w_data_nxt;
            r_last_id  <= w_last_nxt;
            r_busy     <= w_busy_nxt;
            r_rr_ptr   <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign reg_en   = r_reg_en;
    assign reg_data = r_reg_data;
    assign last_id  = r_last_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic checked
// against a slot-timing reference model; also drives a HOLD_CYCLES=0 instance.
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int H = 1;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic           reg_en;
    logic [W-1:0]   reg_data;
    logic [1:0]     last_id;
    logic           busy;

    logic [N-1:0]   req0 = '0;
    logic [N*W-1:0] wdata0 = 16'h0005;
    logic [N-1:0]   gnt0;
    logic           reg_en0;
    logic [W-1:0]   reg_data0;
    logic [1:0]     last_id0;
    logic           busy0;

    // Shared register sitting behind the arbiter (not reset, like the real one).
    logic [W-1:0]   q = '0;

    always #5 clk = ~clk;
    always_ff @(posedge clk) if (reg_en) q <= reg_data;

    reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(rst_n), .req(req), .wdata(wdata), .gnt(gnt),
        .reg_en(reg_en), .reg_data(reg_data), .last_id(last_id), .busy(busy)
    );

    reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(0)) dut_h0 (
        .clk(clk), .reset(rst_n), .req(req0), .wdata(wdata0), .gnt(gnt0),
        .reg_en(reg_en0), .reg_data(reg_data0), .last_id(last_id0), .busy(busy0)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a write may start on any edge at or after m_free.
    int           cyc     = 0;
    int           m_ptr   = 0;
    int           m_free  = 0;
    int           m_gedge = -100;
    logic [N-1:0] e_gnt   = '0;
    logic         e_en    = 1'b0;
    logic [W-1:0] e_data  = '0;
    logic [W-1:0] e_q     = '0;
    logic [1:0]   e_last  = '0;
    logic         e_busy  = 1'b0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_ptr   = 0;
        m_free  = 0;
        m_gedge = -100;
        e_gnt   = '0;
        e_en    = 1'b0;
        e_data  = '0;
        e_last  = '0;
        e_busy  = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req   = '0;
        req0  = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] wd);
        int w;
        req   = r;
        wdata = wd;
        @(posedge clk);
        cyc++;
        if (e_en) e_q = e_data;
        e_gnt = '0;
        e_en  = 1'b0;
        if (cyc >= m_free && r != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            e_gnt   = N'(1) << w;
            e_en    = 1'b1;
            e_data  = wd[w*W +: W];
            e_last  = 2'(w);
            m_ptr   = (w + 1) % N;
            m_free  = cyc + 2 + H;
            m_gedge = cyc;
        end
        e_busy = (cyc >= m_gedge) && (cyc <= m_gedge + H);
        #1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt, reg_en, reg_data, last_id, busy} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got gnt=%b en=%b data=%h last=%0d busy=%b required all 0",
                     gnt, reg_en, reg_data, last_id, busy);
        end
        #1 rst_n = 1'b1;
        model_reset();
        step('0, '0);
        checks++;
        if ({gnt, reg_en, reg_data, last_id, busy} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got gnt=%b en=%b data=%h last=%0d busy=%b required all 0",
                     gnt, reg_en, reg_data, last_id, busy);
        end
    endtask

    task automatic test_single();
        step(4'b0100, 16'h0A00);
        checks++;
        if (gnt !== 4'b0100 || reg_en !== 1'b1 || reg_data !== 4'hA || last_id !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b en=%b data=%h last=%0d busy=%b required 0100 1 a 2 1",
                     gnt, reg_en, reg_data, last_id, busy);
        end
        step('0, 16'h0A00);
        checks++;
        if (gnt !== '0 || reg_en !== 1'b0 || busy !== 1'b1 || q !== 4'hA || reg_data !== 4'hA) begin
            errors++;
            $display("FAIL single_hold: got gnt=%b en=%b busy=%b q=%h data=%h required 0000 0 1 a a",
                     gnt, reg_en, busy, q, reg_data);
        end
        step('0, '0);
        checks++;
        if (busy !== 1'b0 || q !== 4'hA || last_id !== 2'd2) begin
            errors++;
            $display("FAIL single_idle: got busy=%b q=%h last=%0d required 0 a 2", busy, q, last_id);
        end
    endtask

    task automatic test_all_four();
        int winners[$];
        int edges[$];
        int qs[$];
        int exp_w[5] = '{0, 1, 2, 3, 0};
        int prev;
        reset_dut();
        prev = -1;
        for (int i = 0; i < 15; i++) begin
            step(4'b1111, 16'h4321);
            if (prev >= 0) qs.push_back(int'(q));
            prev = -1;
            checks++;
            if (gnt !== e_gnt || reg_en !== e_en) begin
                errors++;
                $display("FAIL all4_model: got gnt=%b en=%b required %b %b", gnt, reg_en, e_gnt, e_en);
            end
            if (gnt != '0) begin
                winners.push_back(onehot_idx(gnt));
                edges.push_back(i);
                prev = onehot_idx(gnt);
            end
        end
        checks++;
        if (winners.size() < 5) begin
            errors++;
            $display("FAIL all4_count: got %0d grants required >=5", winners.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (winners[k] != exp_w[k] || (k < qs.size() && qs[k] != exp_w[k] + 1)) begin
                    errors++;
                    $display("FAIL all4_order[%0d]: got winner=%0d q=%0d required %0d %0d",
                             k, winners[k], (k < qs.size()) ? qs[k] : -1, exp_w[k], exp_w[k] + 1);
                end
                if (k > 0) begin
                    checks++;
                    if (edges[k] - edges[k-1] != 2 + H) begin
                        errors++;
                        $display("FAIL all4_spacing[%0d]: got %0d required %0d", k, edges[k] - edges[k-1], 2 + H);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        int winners[$];
        reset_dut();
        step(4'b1000, 16'h7000);
        checks++;
        if (gnt !== 4'b1000 || last_id !== 2'd3) begin
            errors++;
            $display("FAIL wrap_first: got gnt=%b last=%0d required 1000 3", gnt, last_id);
        end
        step('0, '0);
        step('0, '0);
        for (int i = 0; i < 9; i++) begin
            step(4'b1001, 16'h7001);
            if (gnt != '0) winners.push_back(onehot_idx(gnt));
        end
        checks++;
        if (winners.size() != 3 || winners[0] != 0 || winners[1] != 3 || winners[2] != 0) begin
            errors++;
            $display("FAIL wrap_order: got n=%0d first=%0d required 3 grants 0,3,0",
                     winners.size(), (winners.size() > 0) ? winners[0] : -1);
        end
    endtask

    task automatic test_hold_mask();
        logic [W-1:0] q_before;
        reset_dut();
        step(4'b0001, 16'h0006);
        step('0, '0);
        q_before = q;
        checks++;
        if (busy !== 1'b1 || q_before !== 4'h6) begin
            errors++;
            $display("FAIL hold_enter: got busy=%b q=%h required 1 6", busy, q_before);
        end
        step(4'b0010, 16'h00E0);
        checks++;
        if (gnt !== '0 || reg_en !== 1'b0) begin
            errors++;
            $display("FAIL hold_mask_edge: got gnt=%b en=%b required 0000 0", gnt, reg_en);
        end
        step('0, '0);
        step('0, '0);
        checks++;
        if (gnt !== '0 || reg_en !== 1'b0 || q !== 4'h6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_mask_after: got gnt=%b en=%b q=%h busy=%b required 0000 0 6 0",
                     gnt, reg_en, q, busy);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        step(4'b0010, 16'h0090);
        step('0, '0);
        step('0, '0);
        step(4'b0100, 16'h0B00);
        checks++;
        if (reg_en !== 1'b1 || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL areset_pre: got gnt=%b en=%b required 0100 1", gnt, reg_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== '0 || reg_en !== 1'b0 || reg_data !== '0 || busy !== 1'b0 || last_id !== '0) begin
            errors++;
            $display("FAIL areset_now: got gnt=%b en=%b data=%h busy=%b last=%0d required all 0",
                     gnt, reg_en, reg_data, busy, last_id);
        end
        #1 rst_n = 1'b1;
        model_reset();
        // Requester 2 also asks: a stale pointer (2) would pick it instead of 1.
        step(4'b0110, 16'h0C80);
        checks++;
        if (gnt !== 4'b0010 || reg_data !== 4'h8 || q !== 4'h9) begin
            errors++;
            $display("FAIL areset_restart: got gnt=%b data=%h q=%h required 0010 8 9", gnt, reg_data, q);
        end
        step('0, '0);
        step('0, '0);
    endtask

    task automatic test_hold0();
        reset_dut();
        req0 = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step('0, '0);
            checks++;
            if (gnt0 !== ((i % 2 == 0) ? 4'b0001 : 4'b0000) || busy0 !== reg_en0 || reg_en0 !== (gnt0 != '0)
                || reg_data0 !== 4'h5) begin
                errors++;
                $display("FAIL hold0[%0d]: got gnt=%b en=%b busy=%b data=%h required %b en=busy data 5",
                         i, gnt0, reg_en0, busy0, reg_data0, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            end
        end
        req0 = '0;
    endtask

    task automatic test_random();
        logic [N-1:0]   r;
        logic [N*W-1:0] wd;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            r  = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            wd = (N*W)'($urandom);
            step(r, wd);
            checks++;
            if (gnt !== e_gnt || reg_en !== e_en || reg_data !== e_data || last_id !== e_last
                || busy !== e_busy || q !== e_q) begin
                errors++;
                $display("FAIL random[%0d]: got gnt=%b en=%b data=%h last=%0d busy=%b q=%h required %b %b %h %0d %b %h",
                         i, gnt, reg_en, reg_data, last_id, busy, q, e_gnt, e_en, e_data, e_last, e_busy, e_q);
            end
            checks++;
            if (!$onehot0(gnt) || reg_en !== (gnt != '0)) begin
                errors++;
                $display("FAIL random_onehot[%0d]: got gnt=%b en=%b required onehot0 and en==|gnt", i, gnt, reg_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_hold_mask();
        test_async_reset();
        test_hold0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
